rf_scoreboard: RTL and testbench
================================

// Module: rf_scoreboard
// PURPOSE
//  Parametrised register scoreboard between the instruction decoder and the register file, for N-wide in-order issue.
//  Tracks a busy bit per architectural register, i.e. a write issued but not yet written back.
//  Each cycle, grants the longest in-order prefix of offered instructions that is free of RAW/WAW hazards.
//  Busy bits are cleared by up to WB_WIDTH writebacks per cycle.
// PARAMETERS
//  REGNAME_WIDTH  5  register name width; NUM_REGS = 2**REGNAME_WIDTH (localparam)
//  ISSUE_WIDTH    2  instructions offered per cycle; each has 1 dest and 2 sources
//  WB_WIDTH       2  writeback ports per cycle
//  ZERO_REG_EN    1  1: register 0 never goes busy and is ignored in all hazard checks
// PORTS
//  clk          in   1                        clock, all state updates on rising edge
//  rst          in   1                        synchronous, active-high reset
//  iss_valid    in   ISSUE_WIDTH              lane i offers an instruction
//  iss_wr_en    in   ISSUE_WIDTH              lane i writes a dest register
//  iss_wr_addr  in   ISSUE_WIDTH*REGNAME_WIDTH  dest name, lane i at [i*RW +: RW]
//  iss_rd_en    in   2*ISSUE_WIDTH            source enables, lane i src k at bit 2i+k
//  iss_rd_addr  in   2*ISSUE_WIDTH*REGNAME_WIDTH  source names, lane i src k at [(2i+k)*RW +: RW]
//  iss_grant    out  ISSUE_WIDTH              combinational, lane i issues this cycle
//  wb_valid     in   WB_WIDTH                 writeback j completes this cycle
//  wb_addr      in   WB_WIDTH*REGNAME_WIDTH   writeback j register name
//  flush        in   1                        discard all pending writes
//  busy_vec     out  NUM_REGS                 registered busy bit per register
//  busy_count   out  $clog2(NUM_REGS+1)       registered popcount of busy_vec
//  wb_err       out  1                        sticky: writeback hit a non-busy register
// BEHAVIOUR
//  Reset: busy_vec=0, busy_count=0, wb_err=0. rst takes precedence over every other input.
//  Grant (combinational; depends on current busy_vec and inputs only):
//   - Lane i is granted iff all of:
//     (a) iss_valid[i];
//     (b) every lane j<i is granted (strict in-order prefix; an invalid or stalled lane blocks all later lanes);
//     (c) no enabled source and no enabled dest of lane i is busy in busy_vec;
//     (d) no enabled source and no enabled dest of lane i equals the enabled dest of any lane j<i.
//   - An address with its enable low is never compared.
//   - With ZERO_REG_EN=1, address 0 is never a hazard.
//   - A same-cycle writeback does NOT unblock a stalled lane. Wakeup latency is 1 cycle.
//   - flush=1 forces iss_grant=0 in that cycle.
//   - rst=1 forces iss_grant=0 in that cycle.
//  Busy update (next busy_vec):
//   - A granted lane with wr_en sets busy[wr_addr].
//   - A valid writeback clears busy[wb_addr].
//   - Same register set and cleared in the same cycle: set wins (new pending write survives).
//   - Register 0 is never set when ZERO_REG_EN=1.
//   - Duplicate writeback addresses in one cycle are legal; they clear once.
//   - flush=1: next busy_vec=0; set and clear are ignored that cycle.
//  busy_count equals popcount(busy_vec) every cycle; it is computed from the next-state vector and registered alongside it.
//  wb_err:
//   - Set when wb_valid[j] and busy[wb_addr[j]]=0 in the current state (ZERO_REG_EN=1: addr 0 exempt).
//   - Not set when flush=1.
//   - Cleared only by rst.
//  No latency beyond one register stage. No internal FSM beyond busy/err state.
// TESTING
//  rst 1 cycle -> busy_vec=0, busy_count=0, wb_err=0, iss_grant=0 during rst.
//  Lane0 wr r5, lane1 rd r5, both valid -> grant=01; next cycle busy[5]=1, count=1.
//  busy[5]=1; lane0 reads r5, lane1 independent -> grant=00; cycle of wb r5 -> still 00; next cycle -> 11.
//  Same cycle: lane0 wr r7 granted and wb r7 -> busy[7]=1 next cycle, wb_err=1 if r7 was not busy before.
//  Lane0 wr r0 with ZERO_REG_EN=1 -> busy_vec stays 0, lane1 rd r0 granted (grant=11).
//  Set r3,r4 busy; flush with lane0 valid wr r9 -> grant=00; next cycle busy_vec=0, count=0.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register busy-bit scoreboard for N-wide in-order issue.
// Grants the longest hazard-free in-order prefix of offered instructions
// and clears busy bits on writeback.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   iss_*         : per-lane issue offer (valid, dest, two sources)
//   iss_grant     : combinational per-lane grant
//   wb_valid/addr : writeback ports that clear busy bits
//   flush         : drop all pending writes
//   busy_vec      : registered busy bit per register
//   busy_count    : registered popcount of busy_vec
//   wb_err        : sticky flag, writeback to a non-busy register
module rf_scoreboard #(
   parameter int REGNAME_WIDTH = 5,
   parameter int ISSUE_WIDTH   = 2,
   parameter int WB_WIDTH      = 2,
   parameter bit ZERO_REG_EN   = 1'b1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [ISSUE_WIDTH-1:0]                   iss_valid,
   input  logic [ISSUE_WIDTH-1:0]                   iss_wr_en,
   input  logic [ISSUE_WIDTH*REGNAME_WIDTH-1:0]     iss_wr_addr,
   input  logic [2*ISSUE_WIDTH-1:0]                 iss_rd_en,
   input  logic [2*ISSUE_WIDTH*REGNAME_WIDTH-1:0]   iss_rd_addr,
   output logic [ISSUE_WIDTH-1:0]                   iss_grant,
   input  logic [WB_WIDTH-1:0]                      wb_valid,
   input  logic [WB_WIDTH*REGNAME_WIDTH-1:0]        wb_addr,
   input  logic                                     flush,
   output logic [2**REGNAME_WIDTH-1:0]              busy_vec,
   output logic [$clog2(2**REGNAME_WIDTH+1)-1:0]    busy_count,
   output logic                                     wb_err
);

   localparam int RW = REGNAME_WIDTH;
   localparam int IW = ISSUE_WIDTH;
   localparam int NR = 2**REGNAME_WIDTH;
   localparam int CW = $clog2(NR+1);

   logic [NR-1:0] r_busy;
   logic [CW-1:0] r_count;
   logic          r_err;

   logic [IW-1:0] w_grant;
   logic [NR-1:0] w_set;
   logic [NR-1:0] w_clr;
   logic [NR-1:0] w_next;
   logic [CW-1:0] w_cnt;
   logic          w_err_hit;

   // Register 0 is hardwired when ZERO_REG_EN, so it never participates.
   function automatic logic f_zero(input logic [RW-1:0] a);
      return ZERO_REG_EN && (a == '0);
   endfunction

   // Hazard of one enabled operand of lane `lane`: busy now, or the
   // dest of an older lane in this same group.
   function automatic logic f_haz(
      input logic               en,
      input logic [RW-1:0]      a,
      input int                 lane,
      input logic [NR-1:0]      busy,
      input logic [IW-1:0]      wen,
      input logic [IW*RW-1:0]   waddr
   );
      logic h;
      h = 1'b0;
      if (en && !f_zero(a)) begin
         if (busy[a])
            h = 1'b1;
         for (int j = 0; j < IW; j++)
            if (j < lane && wen[j] && waddr[j*RW +: RW] == a)
               h = 1'b1;
      end
      return h;
   endfunction

   // In-order prefix grant; flush and rst suppress issue entirely.
   always_comb begin
      logic w_prefix;
      logic w_haz;
      w_grant  = '0;
      w_prefix = 1'b1;
      for (int i = 0; i < IW; i++) begin
         w_haz = f_haz(iss_wr_en[i], iss_wr_addr[i*RW +: RW], i,
                       r_busy, iss_wr_en, iss_wr_addr)
               | f_haz(iss_rd_en[2*i], iss_rd_addr[(2*i)*RW +: RW], i,
                       r_busy, iss_wr_en, iss_wr_addr)
               | f_haz(iss_rd_en[2*i+1], iss_rd_addr[(2*i+1)*RW +: RW], i,
                       r_busy, iss_wr_en, iss_wr_addr);
         w_grant[i] = iss_valid[i] && w_prefix && !w_haz && !flush && !rst;
         w_prefix   = w_grant[i];
      end
   end

   // Next busy state: set beats clear so a fresh write survives a
   // writeback of the previous producer in the same cycle.
   always_comb begin
      w_set     = '0;
      w_clr     = '0;
      w_err_hit = 1'b0;
      for (int i = 0; i < IW; i++)
         if (w_grant[i] && iss_wr_en[i] && !f_zero(iss_wr_addr[i*RW +: RW]))
            w_set[iss_wr_addr[i*RW +: RW]] = 1'b1;
      for (int j = 0; j < WB_WIDTH; j++)
         if (wb_valid[j]) begin
            w_clr[wb_addr[j*RW +: RW]] = 1'b1;
            if (!r_busy[wb_addr[j*RW +: RW]] && !f_zero(wb_addr[j*RW +: RW]))
               w_err_hit = 1'b1;
         end
      w_next = flush ? '0 : ((r_busy & ~w_clr) | w_set);
      w_cnt  = '0;
      for (int r = 0; r < NR; r++)
         w_cnt = w_cnt + CW'(w_next[r]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_busy  <= w_next;
         r_count <= w_cnt;
         if (w_err_hit && !flush)
            r_err <= 1'b1;
      end
   end

   assign iss_grant  = w_grant;
   assign busy_vec   = r_busy;
   assign busy_count = r_count;
   assign wb_err     = r_err;

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed self-checking bench for rf_scoreboard.
// Each task drives one scenario and checks grant/busy/err inline.
module tb_rf_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  iss_valid;
   logic [1:0]  iss_wr_en;
   logic [9:0]  iss_wr_addr;
   logic [3:0]  iss_rd_en;
   logic [19:0] iss_rd_addr;
   logic [1:0]  iss_grant;
   logic [1:0]  wb_valid;
   logic [9:0]  wb_addr;
   logic        flush;
   logic [31:0] busy_vec;
   logic [5:0]  busy_count;
   logic        wb_err;

   int errors = 0;
   int checks = 0;

   rf_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .iss_valid   (iss_valid),
      .iss_wr_en   (iss_wr_en),
      .iss_wr_addr (iss_wr_addr),
      .iss_rd_en   (iss_rd_en),
      .iss_rd_addr (iss_rd_addr),
      .iss_grant   (iss_grant),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .flush       (flush),
      .busy_vec    (busy_vec),
      .busy_count  (busy_count),
      .wb_err      (wb_err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      iss_valid   = '0;
      iss_wr_en   = '0;
      iss_wr_addr = '0;
      iss_rd_en   = '0;
      iss_rd_addr = '0;
      wb_valid    = '0;
      wb_addr     = '0;
      flush       = 1'b0;
   endtask

   task automatic lane(input int l, input bit v, input bit we,
                       input logic [4:0] wa, input bit re0,
                       input logic [4:0] ra0, input bit re1,
                       input logic [4:0] ra1);
      iss_valid[l]               = v;
      iss_wr_en[l]               = we;
      iss_wr_addr[l*5 +: 5]      = wa;
      iss_rd_en[2*l]             = re0;
      iss_rd_addr[(2*l)*5 +: 5]  = ra0;
      iss_rd_en[2*l+1]           = re1;
      iss_rd_addr[(2*l+1)*5 +: 5] = ra1;
   endtask

   task automatic wb(input int j, input logic [4:0] a);
      wb_valid[j]       = 1'b1;
      wb_addr[j*5 +: 5] = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_grant(input string nm, input logic [1:0] exp);
      #1;
      checks++;
      if (iss_grant !== exp) begin
         $display("FAIL %s: grant got %b expected %b", nm, iss_grant, exp);
         errors++;
      end
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      lane(0, 1, 1, 5'd1, 0, 0, 0, 0);
      chk_grant("reset_grant", 2'b00);
      tick();
      checks++;
      if (busy_vec !== 32'h0 || busy_count !== 6'd0 || wb_err !== 1'b0) begin
         $display("FAIL reset_state: busy=%h cnt=%0d err=%b expected 0/0/0",
                  busy_vec, busy_count, wb_err);
         errors++;
      end
      idle();
      rst = 1'b0;
   endtask

   task automatic test_raw_intra();
      idle();
      lane(0, 1, 1, 5'd5, 0, 0, 0, 0);
      lane(1, 1, 0, 0, 1, 5'd5, 0, 0);
      chk_grant("raw_grant", 2'b01);
      tick();
      idle();
      checks++;
      if (busy_vec !== 32'h20 || busy_count !== 6'd1) begin
         $display("FAIL raw_busy: busy=%h cnt=%0d expected 00000020/1",
                  busy_vec, busy_count);
         errors++;
      end
   endtask

   task automatic test_stall_wakeup();
      idle();
      lane(0, 1, 0, 0, 1, 5'd5, 0, 0);
      lane(1, 1, 0, 0, 1, 5'd6, 0, 0);
      chk_grant("stall_grant", 2'b00);
      tick();
      chk_grant("stall_hold", 2'b00);
      wb(0, 5'd5);
      chk_grant("stall_wb_same", 2'b00);
      tick();
      wb_valid = '0;
      chk_grant("wakeup_grant", 2'b11);
      checks++;
      if (busy_vec !== 32'h0 || wb_err !== 1'b0) begin
         $display("FAIL wakeup_busy: busy=%h err=%b expected 0/0",
                  busy_vec, wb_err);
         errors++;
      end
      idle();
   endtask

   task automatic test_waw_prefix();
      idle();
      lane(0, 1, 1, 5'd10, 0, 0, 0, 0);
      lane(1, 1, 1, 5'd10, 0, 0, 0, 0);
      chk_grant("waw_grant", 2'b01);
      idle();
      lane(0, 0, 0, 0, 0, 0, 0, 0);
      lane(1, 1, 0, 0, 1, 5'd2, 0, 0);
      chk_grant("prefix_grant", 2'b00);
      idle();
      lane(0, 1, 1, 5'd11, 0, 0, 0, 0);
      lane(1, 1, 1, 5'd12, 0, 5'd11, 0, 5'd11);
      chk_grant("disabled_src", 2'b11);
      idle();
      tick();
   endtask

   task automatic test_zero_reg();
      idle();
      lane(0, 1, 1, 5'd0, 0, 0, 0, 0);
      lane(1, 1, 0, 0, 1, 5'd0, 1, 5'd0);
      wb(0, 5'd0);
      chk_grant("zero_grant", 2'b11);
      tick();
      idle();
      checks++;
      if (busy_vec !== 32'h0 || busy_count !== 6'd0 || wb_err !== 1'b0) begin
         $display("FAIL zero_busy: busy=%h cnt=%0d err=%b expected 0/0/0",
                  busy_vec, busy_count, wb_err);
         errors++;
      end
   endtask

   task automatic test_dup_wb();
      idle();
      lane(0, 1, 1, 5'd13, 0, 0, 0, 0);
      lane(1, 1, 1, 5'd14, 0, 0, 0, 0);
      chk_grant("dup_setup", 2'b11);
      tick();
      idle();
      checks++;
      if (busy_vec !== 32'h6000 || busy_count !== 6'd2) begin
         $display("FAIL dup_setup_busy: busy=%h cnt=%0d expected 00006000/2",
                  busy_vec, busy_count);
         errors++;
      end
      wb(0, 5'd13);
      wb(1, 5'd13);
      tick();
      idle();
      checks++;
      if (busy_vec !== 32'h4000 || busy_count !== 6'd1 || wb_err !== 1'b0) begin
         $display("FAIL dup_wb: busy=%h cnt=%0d err=%b expected 00004000/1/0",
                  busy_vec, busy_count, wb_err);
         errors++;
      end
      wb(0, 5'd14);
      tick();
      idle();
   endtask

   task automatic test_flush();
      idle();
      lane(0, 1, 1, 5'd3, 0, 0, 0, 0);
      lane(1, 1, 1, 5'd4, 0, 0, 0, 0);
      chk_grant("flush_setup", 2'b11);
      tick();
      idle();
      checks++;
      if (busy_vec !== 32'h18 || busy_count !== 6'd2) begin
         $display("FAIL flush_setup_busy: busy=%h cnt=%0d expected 00000018/2",
                  busy_vec, busy_count);
         errors++;
      end
      flush = 1'b1;
      lane(0, 1, 1, 5'd9, 0, 0, 0, 0);
      wb(0, 5'd12);
      chk_grant("flush_grant", 2'b00);
      tick();
      idle();
      checks++;
      if (busy_vec !== 32'h0 || busy_count !== 6'd0 || wb_err !== 1'b0) begin
         $display("FAIL flush_busy: busy=%h cnt=%0d err=%b expected 0/0/0",
                  busy_vec, busy_count, wb_err);
         errors++;
      end
   endtask

   task automatic test_set_clear_same();
      idle();
      lane(0, 1, 1, 5'd7, 0, 0, 0, 0);
      wb(0, 5'd7);
      chk_grant("setclr_grant", 2'b01);
      tick();
      idle();
      checks++;
      if (busy_vec !== 32'h80 || busy_count !== 6'd1 || wb_err !== 1'b1) begin
         $display("FAIL setclr_state: busy=%h cnt=%0d err=%b expected 00000080/1/1",
                  busy_vec, busy_count, wb_err);
         errors++;
      end
      wb(0, 5'd7);
      tick();
      idle();
      checks++;
      if (busy_vec !== 32'h0 || wb_err !== 1'b1) begin
         $display("FAIL err_sticky: busy=%h err=%b expected 0/1",
                  busy_vec, wb_err);
         errors++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (wb_err !== 1'b0) begin
         $display("FAIL err_rst: err=%b expected 0", wb_err);
         errors++;
      end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      test_reset();
      test_raw_intra();
      test_stall_wakeup();
      test_waw_prefix();
      test_zero_reg();
      test_dup_wb();
      test_flush();
      test_set_clear_same();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
